// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the IF/MEM pipeline stages, mem_port_arbiter and the unified memory.
// master = arbiter view, slave = pipeline + memory view.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_done;
  logic [DW-1:0] if_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_done;
  logic [DW-1:0] mem_rdata;

  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ready;
  logic          m_rvalid;
  logic [DW-1:0] m_rdata;

  logic          stall_f;
  logic          stall_m;
  logic          bus_err;

  modport master (
    input  if_req, if_addr, if_flush,
    output if_done, if_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_done, mem_rdata,
    output m_req, m_we, m_addr, m_wdata,
    input  m_ready, m_rvalid, m_rdata,
    output stall_f, stall_m, bus_err
  );

  modport slave (
    output if_req, if_addr, if_flush,
    input  if_done, if_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_done, mem_rdata,
    input  m_req, m_we, m_addr, m_wdata,
    output m_ready, m_rvalid, m_rdata,
    input  stall_f, stall_m, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, data side first, one
// transaction at a time, with fetch kill on flush and a hung-transaction timeout.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus
);

  localparam int unsigned CW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          r_owner_d;
  logic          r_kill;
  logic [CW-1:0] r_cnt;
  logic          r_m_req;
  logic          r_m_we;
  logic [AW-1:0] r_m_addr;
  logic [DW-1:0] r_m_wdata;
  logic          r_if_done;
  logic          r_mem_done;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_mem_rdata;
  logic          r_bus_err;

  logic          w_grant_d;
  logic          w_grant_f;
  logic          w_complete;
  logic          w_abort;
  logic          w_finish;
  logic          w_busy;
  logic          w_timeout;
  logic          w_kill;
  logic          w_if_pend;
  logic          w_mem_pend;
  logic [DW-1:0] w_rdata;

  // A requester whose done is pulsing this cycle is already served; do not re-grant it.
  assign w_if_pend  = bus.if_req  & ~r_if_done;
  assign w_mem_pend = bus.mem_req & ~r_mem_done;
  assign w_busy     = (r_state != S_IDLE);
  assign w_timeout  = (r_cnt == CW'(TIMEOUT - 1));
  assign w_finish   = w_complete | w_abort;
  assign w_kill     = r_kill | bus.if_flush;
  assign w_rdata    = (w_complete && !r_m_we) ? bus.m_rdata : '0;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: response beats timeout in WAIT, timeout beats accept in ISSUE.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_d   = 1'b0;
    w_grant_f   = 1'b0;
    w_complete  = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_pend) begin
          w_grant_d   = 1'b1;
          w_state_nxt = S_ISSUE;
        end else if (w_if_pend) begin
          w_grant_f   = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (w_timeout) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (bus.m_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.m_rvalid) begin
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_timeout) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner_d   <= 1'b0;
      r_kill      <= 1'b0;
      r_cnt       <= '0;
      r_m_req     <= 1'b0;
      r_m_we      <= 1'b0;
      r_m_addr    <= '0;
      r_m_wdata   <= '0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
      r_m_req    <= (w_state_nxt == S_ISSUE);

      if (w_grant_d || w_grant_f) begin
        r_owner_d <= w_grant_d;
        r_m_addr  <= w_grant_d ? bus.mem_addr  : bus.if_addr;
        r_m_we    <= w_grant_d & bus.mem_we;
        r_m_wdata <= w_grant_d ? bus.mem_wdata : '0;
        r_cnt     <= '0;
        r_kill    <= 1'b0;
      end else if (w_busy) begin
        r_cnt <= r_cnt + CW'(1);
      end

      if (w_busy && !r_owner_d && bus.if_flush) r_kill <= 1'b1;

      // Killed fetches finish on the bus but never reach the pipeline.
      if (w_finish) begin
        r_kill <= 1'b0;
        if (r_owner_d) begin
          r_mem_done  <= 1'b1;
          r_mem_rdata <= w_rdata;
        end else if (!w_kill) begin
          r_if_done  <= 1'b1;
          r_if_rdata <= w_rdata;
        end
      end

      if (w_abort) r_bus_err <= 1'b1;
    end
  end

  assign bus.m_req     = r_m_req;
  assign bus.m_we      = r_m_we;
  assign bus.m_addr    = r_m_addr;
  assign bus.m_wdata   = r_m_wdata;
  assign bus.if_done   = r_if_done;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.mem_done  = r_mem_done;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.bus_err   = r_bus_err;
  assign bus.stall_f   = w_if_pend;
  assign bus.stall_m   = w_mem_pend;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: the transaction in flight plus the registered outputs expected after each edge.
  bit          md_busy, md_own_d, md_acc, md_kill, md_we;
  logic [31:0] md_addr, md_wdata;
  int          md_age;
  bit          exp_if_done, exp_mem_done, exp_err;
  logic [31:0] exp_if_rdata, exp_mem_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit fin, ab;
    logic [31:0] rd;
    fin = 1'b0;
    ab  = 1'b0;
    if (reset) begin
      md_busy = 0; md_own_d = 0; md_acc = 0; md_kill = 0; md_we = 0;
      md_addr = 0; md_wdata = 0; md_age = 0;
      exp_if_done = 0; exp_mem_done = 0; exp_err = 0;
      exp_if_rdata = 0; exp_mem_rdata = 0;
    end else if (!md_busy) begin
      if (bus.mem_req && !exp_mem_done) begin
        md_busy = 1; md_own_d = 1; md_addr = bus.mem_addr;
        md_we = bus.mem_we; md_wdata = bus.mem_wdata;
      end else if (bus.if_req && !exp_if_done) begin
        md_busy = 1; md_own_d = 0; md_addr = bus.if_addr;
        md_we = 0; md_wdata = 0;
      end
      md_acc = 0; md_age = 0; md_kill = 0;
      exp_if_done = 0; exp_mem_done = 0;
    end else begin
      exp_if_done = 0; exp_mem_done = 0;
      if (!md_own_d && bus.if_flush) md_kill = 1;
      if (md_acc && bus.m_rvalid)     fin = 1;
      else if (md_age == TO - 1)      ab = 1;
      else if (!md_acc && bus.m_ready) md_acc = 1;
      md_age++;
      if (fin || ab) begin
        rd = (fin && !md_we) ? bus.m_rdata : 32'h0;
        if (md_own_d) begin
          exp_mem_done = 1; exp_mem_rdata = rd;
        end else if (!md_kill) begin
          exp_if_done = 1; exp_if_rdata = rd;
        end
        if (ab) exp_err = 1;
        md_busy = 0;
      end
    end
  endtask

  // Advance one clock; the model predicts the edge from the inputs currently driven.
  task automatic tick();
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic serve(input logic [31:0] rdata);
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready  = 1'b0;
    bus.m_rvalid = 1'b1;
    bus.m_rdata  = rdata;
    tick();
    bus.m_rvalid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("if_done",   32'(bus.if_done),   32'(exp_if_done));
      chk("mem_done",  32'(bus.mem_done),  32'(exp_mem_done));
      chk("if_rdata",  bus.if_rdata,       exp_if_rdata);
      chk("mem_rdata", bus.mem_rdata,      exp_mem_rdata);
      chk("bus_err",   32'(bus.bus_err),   32'(exp_err));
      chk("m_req",     32'(bus.m_req),     32'(md_busy && !md_acc));
      chk("stall_f",   32'(bus.stall_f),   32'(bus.if_req && !exp_if_done));
      chk("stall_m",   32'(bus.stall_m),   32'(bus.mem_req && !exp_mem_done));
      chk("done_excl", 32'(bus.if_done & bus.mem_done), 32'h0);
      if (md_busy && !md_acc) begin
        chk("m_addr",  bus.m_addr,     md_addr);
        chk("m_we",    32'(bus.m_we),  32'(md_we));
        chk("m_wdata", bus.m_wdata,    md_wdata);
      end
    end
  end

  initial begin
    bit hang;
    hang          = 1'b0;
    reset         = 1'b1;
    bus.if_req    = 0; bus.if_addr  = 0; bus.if_flush  = 0;
    bus.mem_req   = 0; bus.mem_we   = 0; bus.mem_addr  = 0; bus.mem_wdata = 0;
    bus.m_ready   = 0; bus.m_rvalid = 0; bus.m_rdata   = 0;
    @(negedge clk);
    #1;
    tick();
    tick();
    chk_en = 1'b1;
    reset  = 1'b0;
    chk("rst_m_addr",   bus.m_addr,       32'h0);
    chk("rst_m_wdata",  bus.m_wdata,      32'h0);
    chk("rst_m_we",     32'(bus.m_we),    32'h0);
    chk("rst_if_rdata", bus.if_rdata,     32'h0);

    // Single fetch at minimum latency.
    bus.if_req = 1; bus.if_addr = 32'h100;
    tick();
    chk("sf_m_req",  32'(bus.m_req),   32'h1);
    chk("sf_m_addr", bus.m_addr,       32'h100);
    chk("sf_stall1", 32'(bus.stall_f), 32'h1);
    bus.m_ready = 1;
    tick();
    chk("sf_m_req0", 32'(bus.m_req),   32'h0);
    chk("sf_stall2", 32'(bus.stall_f), 32'h1);
    bus.m_ready = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h00500093;
    tick();
    chk("sf_done",     32'(bus.if_done), 32'h1);
    chk("sf_rdata",    bus.if_rdata,     32'h00500093);
    chk("sf_stall3",   32'(bus.stall_f), 32'h0);
    chk("model_sf",    exp_if_rdata,     32'h00500093);
    bus.if_req = 0; bus.m_rvalid = 0;
    tick();
    chk("sf_done_off", 32'(bus.if_done), 32'h0);

    // Contention: load wins, fetch granted in the cycle mem_done pulses.
    bus.if_req = 1; bus.if_addr = 32'h300;
    bus.mem_req = 1; bus.mem_we = 0; bus.mem_addr = 32'h2000;
    tick();
    chk("ct_m_addr", bus.m_addr, 32'h2000);
    serve(32'hDEADBEEF);
    chk("ct_mem_done",  32'(bus.mem_done), 32'h1);
    chk("ct_mem_rdata", bus.mem_rdata,     32'hDEADBEEF);
    chk("ct_if_idle",   32'(bus.if_done),  32'h0);
    tick();
    bus.mem_req = 0;
    chk("ct_f_addr", bus.m_addr,     32'h300);
    chk("ct_f_req",  32'(bus.m_req), 32'h1);
    serve(32'h00000013);
    chk("ct_if_done",  32'(bus.if_done), 32'h1);
    chk("ct_if_rdata", bus.if_rdata,     32'h00000013);
    bus.if_req = 0;
    tick();

    // Store with three wait states; inputs wiggle after grant and must be ignored.
    bus.mem_req = 1; bus.mem_we = 1; bus.mem_addr = 32'h2004; bus.mem_wdata = 32'h12345678;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("st_m_req",   32'(bus.m_req), 32'h1);
      chk("st_m_addr",  bus.m_addr,     32'h2004);
      chk("st_m_wdata", bus.m_wdata,    32'h12345678);
      chk("st_m_we",    32'(bus.m_we),  32'h1);
      bus.mem_addr  = 32'hBAD0;
      bus.mem_wdata = 32'hCAFEF00D;
      bus.m_ready   = (k == 3);
      tick();
    end
    bus.m_ready = 0; bus.m_rvalid = 1; bus.m_rdata = 32'hFFFFFFFF;
    tick();
    chk("st_done",  32'(bus.mem_done), 32'h1);
    chk("st_rdata", bus.mem_rdata,     32'h0);
    bus.mem_req = 0; bus.m_rvalid = 0;
    tick();

    // Flush during WAIT kills the fetch; the redirected fetch then completes.
    bus.if_req = 1; bus.if_addr = 32'h400;
    tick();
    bus.m_ready = 1;
    tick();
    bus.m_ready = 0; bus.if_flush = 1; bus.if_addr = 32'h200;
    tick();
    bus.if_flush = 0; bus.m_rvalid = 1; bus.m_rdata = 32'hAAAA5555;
    tick();
    chk("fl_no_done", 32'(bus.if_done), 32'h0);
    bus.m_rvalid = 0;
    tick();
    chk("fl_m_addr", bus.m_addr, 32'h200);
    serve(32'h00108093);
    chk("fl_done",  32'(bus.if_done), 32'h1);
    chk("fl_rdata", bus.if_rdata,     32'h00108093);
    bus.if_req = 0;
    tick();

    // Timeout: memory never accepts.
    bus.mem_req = 1; bus.mem_we = 0; bus.mem_addr = 32'h3000;
    tick();
    for (int k = 0; k < TO; k++) begin
      chk("to_m_req", 32'(bus.m_req), 32'h1);
      tick();
    end
    chk("to_m_req0",  32'(bus.m_req),    32'h0);
    chk("to_done",    32'(bus.mem_done), 32'h1);
    chk("to_rdata",   bus.mem_rdata,     32'h0);
    chk("to_err",     32'(bus.bus_err),  32'h1);
    chk("model_err",  32'(exp_err),      32'h1);
    bus.mem_req = 0;
    tick();
    bus.m_rvalid = 1; bus.m_rdata = 32'h5A5A5A5A;
    tick();
    chk("to_late_rv", 32'(bus.mem_done | bus.if_done), 32'h0);
    chk("to_sticky",  32'(bus.bus_err), 32'h1);
    bus.m_rvalid = 0;
    tick();

    // Reset in WAIT abandons the transaction.
    bus.if_req = 1; bus.if_addr = 32'h500;
    tick();
    bus.m_ready = 1;
    tick();
    bus.m_ready = 0; reset = 1; bus.if_req = 0; bus.m_rvalid = 1;
    tick();
    chk("rs_m_req",     32'(bus.m_req),   32'h0);
    chk("rs_err",       32'(bus.bus_err), 32'h0);
    chk("rs_if_rdata",  bus.if_rdata,     32'h0);
    chk("rs_m_addr",    bus.m_addr,       32'h0);
    reset = 0;
    tick();
    chk("rs_no_done", 32'(bus.if_done | bus.mem_done), 32'h0);
    bus.m_rvalid = 0;
    tick();

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) hang = ($urandom_range(0, 3) == 0);
      if (exp_if_done || !bus.if_req) begin
        bus.if_req  = ($urandom_range(0, 2) != 0);
        bus.if_addr = $urandom & 32'hFFFF_FFFC;
      end else if ($urandom_range(0, 15) == 0) begin
        bus.if_addr = $urandom;
      end
      bus.if_flush = bus.if_req && ($urandom_range(0, 9) == 0);
      if (bus.if_flush) bus.if_addr = $urandom & 32'hFFFF_FFFC;
      if (exp_mem_done || !bus.mem_req) begin
        bus.mem_req   = ($urandom_range(0, 2) == 0);
        bus.mem_we    = 1'($urandom_range(0, 1));
        bus.mem_addr  = $urandom;
        bus.mem_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        bus.mem_wdata = $urandom;
      end
      bus.m_ready  = hang ? 1'b0 : 1'($urandom_range(0, 1));
      bus.m_rvalid = hang ? 1'b0 :
                     (md_busy && md_acc) ? ($urandom_range(0, 2) == 0) :
                                           ($urandom_range(0, 7) == 0);
      bus.m_rdata  = $urandom;
      reset        = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
